// File: rtl/case_encoder_if.sv
// Handshake bundle for case_encoder: one-hot selector in, encoded code out.
// The master side drives in_valid/in_data/out_ready; the encoder is the slave.
interface case_encoder_if;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [1:0] out_code;
    logic       out_ready;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_code
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_code
    );
endinterface

// File: rtl/case_encoder.sv
// One-hot to binary encoder with a one-entry output register and saturating per-code hit counters.
// Optional macro ENC_ILLEGAL_TRAP_EN: illegal input sets a sticky err and locks the block until reset.
module case_encoder #(
    parameter int CNT_W = 8
) (
    input  logic               clock,
    input  logic               reset,
    case_encoder_if.slave      bus,
    output logic               err,
    output logic [4*CNT_W-1:0] hit_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FULL = 2'd1
`ifdef ENC_ILLEGAL_TRAP_EN
        ,
        TRAP = 2'd2
`endif
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         code_q, code_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   cnt_q [4];
    logic [CNT_W-1:0]   cnt_d [4];

    logic               legal;
    logic [1:0]         enc;
    logic               out_valid;
    logic               in_ready;
    logic               accept;
    logic               drain;

    always_comb begin
        legal = 1'b1;
        enc   = 2'b00;
        case (bus.in_data)
            4'b0001: enc = 2'b00;
            4'b0010: enc = 2'b01;
            4'b0100: enc = 2'b10;
            4'b1000: enc = 2'b11;
            default: legal = 1'b0;
        endcase
    end

    assign out_valid = (state_q == FULL);
`ifdef ENC_ILLEGAL_TRAP_EN
    assign in_ready  = (state_q != TRAP) && (!out_valid || bus.out_ready);
`else
    assign in_ready  = !out_valid || bus.out_ready;
`endif
    assign accept    = bus.in_valid && in_ready;
    assign drain     = out_valid && bus.out_ready;

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves it unassigned (no latch).
        state_d = state_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
`ifdef ENC_ILLEGAL_TRAP_EN
        err_d   = err_q || (accept && !legal);
`else
        err_d   = accept && !legal;
`endif

        case (state_q)
            IDLE: if (accept && legal) state_d = FULL;
            FULL: if (drain && !(accept && legal)) state_d = IDLE;
`ifdef ENC_ILLEGAL_TRAP_EN
            TRAP: state_d = TRAP;
`endif
            default: state_d = IDLE;
        endcase

`ifdef ENC_ILLEGAL_TRAP_EN
        // A pending output drains in the same cycle, so the trap never strands valid data.
        if (accept && !legal) state_d = TRAP;
`endif

        if (accept && legal) begin
            code_d = enc;
            if (cnt_q[enc] != {CNT_W{1'b1}}) cnt_d[enc] = cnt_q[enc] + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
        if (reset) begin
            state_q <= IDLE;
            code_q  <= 2'b00;
            err_q   <= 1'b0;
            // NOTE: the counters are architecturally visible, so this small array is reset, unlike a data RAM.
            cnt_q   <= '{default: '0};
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_code  = code_q;
    assign err           = err_q;

    for (genvar n = 0; n < 4; n++) begin : g_hit
        assign hit_cnt[n*CNT_W +: CNT_W] = cnt_q[n];
    end

endmodule

// File: tb/tb_case_encoder.sv
// Directed + random bench for case_encoder: reference model plus a queue scoreboard of accepted codes.
// Trap-policy checks are selected with the same ENC_ILLEGAL_TRAP_EN macro as the design.
module tb_case_encoder;

    localparam int CNT_W = 8;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               err;
    logic [4*CNT_W-1:0] hit_cnt;

    case_encoder_if bus ();

    case_encoder #(.CNT_W(CNT_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .bus     (bus),
        .err     (err),
        .hit_cnt (hit_cnt)
    );

    always #5 clock = ~clock;

    int unsigned n_cmp  = 0;
    int unsigned n_fail = 0;

    logic             m_valid;
    logic [1:0]       m_code;
    logic [CNT_W-1:0] m_cnt [4];
    logic             m_err;
    logic             m_trap;
    logic [1:0]       sb [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] onehot_idx(input logic [3:0] d);
        logic [1:0] idx = 2'b00;
        for (int i = 0; i < 4; i++) if (d[i]) idx = 2'(i);
        return idx;
    endfunction

    task automatic check_outputs(input string tag);
        check({tag, ".out_valid"}, bus.out_valid, m_valid);
        check({tag, ".out_code"},  bus.out_code,  m_code);
        check({tag, ".err"},       err,           m_err);
        check({tag, ".hit_cnt"},   hit_cnt,       {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]});
    endtask

    // One clock of stimulus: drive at negedge, check ready/drain before the edge, outputs after it.
    task automatic step(input logic v, input logic [3:0] d, input logic r);
        logic       exp_ready, acc, lg;
        logic [1:0] c;
        @(negedge clock);
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        #1;
        exp_ready = !m_trap && (!m_valid || r);
        check("in_ready", bus.in_ready, exp_ready);
        if (bus.out_valid && r) begin
            if (sb.size() > 0) check("drain_code", bus.out_code, sb.pop_front());
            else               check("drain_sb_depth", sb.size(), 1);
        end
        acc = v && exp_ready;
        lg  = ($countones(d) == 1);
        c   = onehot_idx(d);
        @(posedge clock);
        if (m_valid && r) m_valid = 1'b0;
`ifdef ENC_ILLEGAL_TRAP_EN
        m_err = m_err || (acc && !lg);
        if (acc && !lg) m_trap = 1'b1;
`else
        m_err = acc && !lg;
`endif
        if (acc && lg) begin
            m_valid = 1'b1;
            m_code  = c;
            sb.push_back(c);
            if (m_cnt[c] != {CNT_W{1'b1}}) m_cnt[c] = m_cnt[c] + 1'b1;
        end
        #1;
        check_outputs("step");
    endtask

    task automatic do_reset(input logic v, input logic [3:0] d, input logic r);
        @(negedge clock);
        reset         = 1'b1;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.out_ready = r;
        @(posedge clock);
        m_valid = 1'b0;
        m_code  = 2'b00;
        m_err   = 1'b0;
        m_trap  = 1'b0;
        m_cnt   = '{default: '0};
        sb.delete();
        #1;
        check_outputs("reset");
        check("reset.in_ready", bus.in_ready, 1'b1);
        @(negedge clock);
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'b0000;
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 4'b0000;
        bus.out_ready = 1'b1;
        m_valid = 1'b0;
        m_code  = 2'b00;
        m_err   = 1'b0;
        m_trap  = 1'b0;
        m_cnt   = '{default: '0};
        repeat (2) @(posedge clock);

        // Reset state
        do_reset(1'b0, 4'b0000, 1'b1);

        // Basic encode, latency 1, counter for code 2
        step(1'b1, 4'b0100, 1'b1);
        check("code2_cnt", hit_cnt[2*CNT_W +: CNT_W], 8'd1);
        step(1'b0, 4'b0000, 1'b1);

        // Backpressure: hold output, block input for 5 cycles, then drain
        step(1'b1, 4'b0001, 1'b0);
        repeat (5) step(1'b1, 4'b0010, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

        // Simultaneous drain and accept keeps FULL
        step(1'b1, 4'b0010, 1'b1);
        step(1'b1, 4'b1000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);

`ifdef ENC_ILLEGAL_TRAP_EN
        // Illegal input traps until reset; counters frozen
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0011, 1'b1);
        repeat (3) step(1'b1, 4'b0001, 1'b1);
        do_reset(1'b0, 4'b0000, 1'b1);
`else
        // Illegal input dropped with a one-cycle err pulse
        step(1'b1, 4'b0000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        step(1'b1, 4'b0001, 1'b1);
        step(1'b1, 4'b0110, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
`endif

        // Reset while FULL and stalled discards the pending output
        step(1'b1, 4'b0100, 1'b0);
        do_reset(1'b1, 4'b0010, 1'b0);

        // Saturation of code 3 counter
        repeat (300) step(1'b1, 4'b1000, 1'b1);
        check("code3_sat", hit_cnt[3*CNT_W +: CNT_W], 8'hFF);
        step(1'b0, 4'b0000, 1'b1);

        // Random traffic
        do_reset(1'b0, 4'b0000, 1'b1);
        for (int i = 0; i < 200; i++) begin
            logic [3:0] d;
            d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : (4'b0001 << $urandom_range(0, 3));
            step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
